// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller: latch enables for load-use, branch flush and multdiv handshake
module pipeline_stall_controller #(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      FD_Latch_Instr,
    input  logic [31:0]      DX_Latch_Instr,
    input  logic             branch_taken,
    input  logic             md_rdy,
    input  logic             md_exception,
    input  logic [31:0]      md_data,
    output logic             pc_we,
    output logic             fd_we,
    output logic             dx_we,
    output logic             fd_flush,
    output logic             dx_nop,
    output logic             xm_nop,
    output logic             md_start_mult,
    output logic             md_start_div,
    output logic [31:0]      md_result,
    output logic             md_result_exc,
    output logic             md_busy,
    output logic             md_timeout,
    output logic [CNT_W-1:0] stall_cycles
);
    localparam int              TO_W    = $clog2(MD_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MD_TIMEOUT - 1);
    localparam logic [4:0] OP_R    = 5'd0;
    localparam logic [4:0] OP_BNE  = 5'd2;
    localparam logic [4:0] OP_JR   = 5'd4;
    localparam logic [4:0] OP_ADDI = 5'd5;
    localparam logic [4:0] OP_BLT  = 5'd6;
    localparam logic [4:0] OP_SW   = 5'd7;
    localparam logic [4:0] OP_LW   = 5'd8;
    localparam logic [4:0] OP_BEX  = 5'd22;
    localparam logic [4:0] ALU_MUL = 5'd6;
    localparam logic [4:0] ALU_DIV = 5'd7;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_q, state_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [31:0]       res_q, res_d;
    logic              exc_q, exc_d;
    logic              tmo_q, tmo_d;
    logic [CNT_W-1:0]  stall_q;

    logic [4:0] fd_op, fd_rd, fd_rs, fd_rt, dx_op, dx_rd, dx_alu;
    logic       reads_rs, reads_rt, reads_rd, reads_r30;
    logic       dx_md, lu, md_stall, start;
    logic       unused_bits;

    assign fd_op  = FD_Latch_Instr[31:27];
    assign fd_rd  = FD_Latch_Instr[26:22];
    assign fd_rs  = FD_Latch_Instr[21:17];
    assign fd_rt  = FD_Latch_Instr[16:12];
    assign dx_op  = DX_Latch_Instr[31:27];
    assign dx_rd  = DX_Latch_Instr[26:22];
    assign dx_alu = DX_Latch_Instr[6:2];
    assign unused_bits = ^{FD_Latch_Instr[11:0], DX_Latch_Instr[21:7], DX_Latch_Instr[1:0]};

    // sw data (rd) is forwarded by the WM bypass, so sw only interlocks on its base register
    assign reads_rs  = fd_op inside {OP_R, OP_ADDI, OP_LW, OP_SW, OP_BNE, OP_BLT};
    assign reads_rt  = fd_op == OP_R;
    assign reads_rd  = fd_op inside {OP_BNE, OP_BLT, OP_JR};
    assign reads_r30 = fd_op == OP_BEX;

    assign lu = (dx_op == OP_LW) && (dx_rd != 5'd0) &&
                ((reads_rs && fd_rs == dx_rd) || (reads_rt && fd_rt == dx_rd) ||
                 (reads_rd && fd_rd == dx_rd) || (reads_r30 && dx_rd == 5'd30));

    assign dx_md    = (dx_op == OP_R) && (dx_alu == ALU_MUL || dx_alu == ALU_DIV);
    assign start    = (state_q == IDLE) && dx_md;
    assign md_stall = start || (state_q == BUSY);

    assign md_start_mult = reset && start && (dx_alu == ALU_MUL);
    assign md_start_div  = reset && start && (dx_alu == ALU_DIV);
    assign md_busy       = state_q == BUSY;
    assign md_result     = res_q;
    assign md_result_exc = exc_q;
    assign md_timeout    = tmo_q;
    assign stall_cycles  = stall_q;

    // multdiv FSM next state, timeout counter and result hold register
    always_comb begin
        state_d  = state_q;
        to_cnt_d = to_cnt_q;
        res_d    = res_q;
        exc_d    = exc_q;
        tmo_d    = tmo_q;
        case (state_q)
            IDLE: begin
                if (dx_md) begin
                    to_cnt_d = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (md_rdy) begin
                    res_d   = md_data;
                    exc_d   = md_exception;
                    state_d = DONE;
                end else if (to_cnt_q == TO_LAST) begin
                    res_d   = '0;
                    exc_d   = 1'b1;
                    tmo_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // latch controls by priority: multdiv stall, taken branch, load-use bubble, normal flow
    always_comb begin
        pc_we    = 1'b0;
        fd_we    = 1'b0;
        dx_we    = 1'b0;
        fd_flush = 1'b0;
        dx_nop   = 1'b0;
        xm_nop   = 1'b0;
        if (reset) begin
            if (md_stall) begin
                xm_nop = 1'b1;
            end else if (branch_taken) begin
                pc_we    = 1'b1;
                fd_we    = 1'b1;
                dx_we    = 1'b1;
                fd_flush = 1'b1;
                dx_nop   = 1'b1;
            end else if (lu) begin
                dx_we  = 1'b1;
                dx_nop = 1'b1;
            end else begin
                pc_we = 1'b1;
                fd_we = 1'b1;
                dx_we = 1'b1;
            end
        end
    end

    // FSM and hold register state
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            to_cnt_q <= '0;
            res_q    <= '0;
            exc_q    <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            to_cnt_q <= to_cnt_d;
            res_q    <= res_d;
            exc_q    <= exc_d;
            tmo_q    <= tmo_d;
        end
    end

    // saturating count of cycles in which the PC is held
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
        end else if (!pc_we && stall_q != '1) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb_pipeline_stall_controller: vector table plus multdiv/reset sequences against two parameterisations
module tb_pipeline_stall_controller;
    localparam logic [7:0] C_NORM = 8'b1110_0000;
    localparam logic [7:0] C_LU   = 8'b0010_1000;
    localparam logic [7:0] C_BR   = 8'b1111_1000;
    localparam logic [7:0] C_MDM  = 8'b0000_0110;
    localparam logic [7:0] C_MDD  = 8'b0000_0101;
    localparam logic [7:0] C_BUSY = 8'b0000_0100;
    localparam logic [7:0] C_RST  = 8'b0000_0000;

    logic        clock = 1'b0, reset = 1'b0;
    logic [31:0] fd_i = '0, dx_i = '0, md_data = '0;
    logic        br = 1'b0, md_rdy = 1'b0, md_exc = 1'b0;

    logic        pc_we, fd_we, dx_we, fd_flush, dx_nop, xm_nop, sm, sd;
    logic [31:0] md_result, stall_cycles;
    logic        md_result_exc, md_busy, md_timeout;

    logic        t_pc_we, t_fd_we, t_dx_we, t_fd_flush, t_dx_nop, t_xm_nop, t_sm, t_sd;
    logic [31:0] t_result;
    logic [3:0]  t_stall;
    logic        t_exc, t_busy, t_timeout;

    pipeline_stall_controller dut (
        .clock(clock), .reset(reset), .FD_Latch_Instr(fd_i), .DX_Latch_Instr(dx_i),
        .branch_taken(br), .md_rdy(md_rdy), .md_exception(md_exc), .md_data(md_data),
        .pc_we(pc_we), .fd_we(fd_we), .dx_we(dx_we), .fd_flush(fd_flush), .dx_nop(dx_nop),
        .xm_nop(xm_nop), .md_start_mult(sm), .md_start_div(sd), .md_result(md_result),
        .md_result_exc(md_result_exc), .md_busy(md_busy), .md_timeout(md_timeout),
        .stall_cycles(stall_cycles)
    );

    pipeline_stall_controller #(.MD_TIMEOUT(8), .CNT_W(4)) dut8 (
        .clock(clock), .reset(reset), .FD_Latch_Instr(fd_i), .DX_Latch_Instr(dx_i),
        .branch_taken(br), .md_rdy(md_rdy), .md_exception(md_exc), .md_data(md_data),
        .pc_we(t_pc_we), .fd_we(t_fd_we), .dx_we(t_dx_we), .fd_flush(t_fd_flush), .dx_nop(t_dx_nop),
        .xm_nop(t_xm_nop), .md_start_mult(t_sm), .md_start_div(t_sd), .md_result(t_result),
        .md_result_exc(t_exc), .md_busy(t_busy), .md_timeout(t_timeout),
        .stall_cycles(t_stall)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] fd;
        logic [31:0] dx;
        logic        br;
        logic [7:0]  exp;
    } vec_t;

    int         checks = 0, failures = 0, exp_stall = 0;
    logic [7:0] sb[$];
    vec_t       vt[20];

    function automatic logic [31:0] enc_r(input logic [4:0] alu, rd, rs, rt);
        return {5'd0, rd, rs, rt, 5'd0, alu, 2'b00};
    endfunction

    function automatic logic [31:0] enc_i(input logic [4:0] op, rd, rs, input logic [16:0] imm);
        return {op, rd, rs, imm};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // drive one cycle; expected controls go through the scoreboard and are checked at negedge
    task automatic step(input string name, input logic [31:0] fd, dx, input logic b, rdy, ex,
                        input logic [31:0] d, input logic rv, input logic [7:0] e);
        logic [7:0] want;
        @(posedge clock);
        #1;
        reset = rv; fd_i = fd; dx_i = dx; br = b; md_rdy = rdy; md_exc = ex; md_data = d;
        if (!rv) exp_stall = 0;
        sb.push_back(e);
        @(negedge clock);
        want = sb.pop_front();
        chk({name, " ctl"}, 32'({pc_we, fd_we, dx_we, fd_flush, dx_nop, xm_nop, sm, sd}), 32'(want));
        chk({name, " stall_cycles"}, stall_cycles, 32'(exp_stall));
        if (rv && !want[7]) exp_stall++;
    endtask

    task automatic st(input string name, input logic [31:0] fd, dx, input logic [7:0] e);
        step(name, fd, dx, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, e);
    endtask

    task automatic do_reset();
        step("reset", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, C_RST);
        step("reset", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, C_RST);
    endtask

    initial begin
        logic [31:0] add, add2, mul, dv, lw5;
        add  = enc_r(5'd0, 5'd6, 5'd5, 5'd2);
        add2 = enc_r(5'd0, 5'd7, 5'd1, 5'd2);
        mul  = enc_r(5'd6, 5'd3, 5'd1, 5'd2);
        dv   = enc_r(5'd7, 5'd3, 5'd1, 5'd2);
        lw5  = enc_i(5'd8, 5'd5, 5'd1, 17'd0);
        vt[0]  = '{add, lw5, 1'b0, C_LU};
        vt[1]  = '{enc_r(5'd0, 5'd6, 5'd2, 5'd5), lw5, 1'b0, C_LU};
        vt[2]  = '{enc_r(5'd0, 5'd6, 5'd1, 5'd2), lw5, 1'b0, C_NORM};
        vt[3]  = '{enc_r(5'd0, 5'd6, 5'd0, 5'd0), enc_i(5'd8, 5'd0, 5'd1, 17'd0), 1'b0, C_NORM};
        vt[4]  = '{enc_i(5'd7, 5'd5, 5'd1, 17'd0), lw5, 1'b0, C_NORM};
        vt[5]  = '{enc_i(5'd7, 5'd1, 5'd5, 17'd0), lw5, 1'b0, C_LU};
        vt[6]  = '{enc_i(5'd2, 5'd5, 5'd1, 17'd0), lw5, 1'b0, C_LU};
        vt[7]  = '{enc_i(5'd6, 5'd1, 5'd5, 17'd0), lw5, 1'b0, C_LU};
        vt[8]  = '{enc_i(5'd4, 5'd5, 5'd0, 17'd0), lw5, 1'b0, C_LU};
        vt[9]  = '{enc_i(5'd22, 5'd0, 5'd0, 17'd0), enc_i(5'd8, 5'd30, 5'd1, 17'd0), 1'b0, C_LU};
        vt[10] = '{enc_i(5'd22, 5'd0, 5'd0, 17'd0), lw5, 1'b0, C_NORM};
        vt[11] = '{enc_i(5'd5, 5'd6, 5'd5, 17'd1), lw5, 1'b0, C_LU};
        vt[12] = '{enc_i(5'd1, 5'd5, 5'd5, 17'd0), lw5, 1'b0, C_NORM};
        vt[13] = '{add, enc_r(5'd0, 5'd5, 5'd1, 5'd2), 1'b0, C_NORM};
        vt[14] = '{add, enc_i(5'd2, 5'd1, 5'd2, 17'd0), 1'b1, C_BR};
        vt[15] = '{add, lw5, 1'b1, C_BR};
        vt[16] = '{enc_i(5'd3, 5'd5, 5'd5, 17'd0), lw5, 1'b0, C_NORM};
        vt[17] = '{add, enc_i(5'd7, 5'd5, 5'd1, 17'd0), 1'b0, C_NORM};
        vt[18] = '{enc_r(5'd0, 5'd6, 5'd1, 5'd2), lw5, 1'b1, C_BR};
        vt[19] = '{enc_i(5'd5, 5'd5, 5'd1, 17'd0), lw5, 1'b0, C_NORM};

        do_reset();
        for (int i = 0; i < 20; i++)
            step($sformatf("vec%0d", i), vt[i].fd, vt[i].dx, vt[i].br, 1'b0, 1'b0, 32'h0, 1'b1, vt[i].exp);

        st("lu_hit", add, lw5, C_LU);
        st("lu_bubble", add, 32'h0, C_NORM);
        st("lu_advance", add2, add, C_NORM);
        chk("lu md_busy", 32'(md_busy), 32'h0);

        do_reset();
        step("mul_start", add, mul, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, C_MDM);
        chk("mul_start md_busy", 32'(md_busy), 32'h0);
        for (int i = 1; i < 10; i++) begin
            st("mul_busy", add, mul, C_BUSY);
            chk("mul_busy md_busy", 32'(md_busy), 32'h1);
        end
        step("mul_rdy", add, mul, 1'b0, 1'b1, 1'b0, 32'h0000_0F00, 1'b1, C_BUSY);
        st("mul_done", add, mul, C_NORM);
        chk("mul_done md_result", md_result, 32'h0000_0F00);
        chk("mul_done md_result_exc", 32'(md_result_exc), 32'h0);
        chk("mul_done md_busy", 32'(md_busy), 32'h0);
        chk("mul_done stall_cycles", stall_cycles, 32'd11);
        st("div_b2b_start", add, dv, C_MDD);
        step("div_rdy", add, dv, 1'b0, 1'b1, 1'b1, 32'h0000_ABCD, 1'b1, C_BUSY);
        st("div_done", add, dv, C_NORM);
        chk("div_done md_result", md_result, 32'h0000_ABCD);
        chk("div_done md_result_exc", 32'(md_result_exc), 32'h1);
        step("stray_rdy", add2, add, 1'b0, 1'b1, 1'b0, 32'h0000_1234, 1'b1, C_NORM);
        st("after_stray", add2, add, C_NORM);
        chk("after_stray md_result", md_result, 32'h0000_ABCD);
        chk("after_stray md_busy", 32'(md_busy), 32'h0);
        chk("after_stray md_timeout", 32'(md_timeout), 32'h0);

        do_reset();
        st("to_start", add, dv, C_MDD);
        chk("to_start t_start_div", 32'(t_sd), 32'h1);
        for (int i = 1; i <= 8; i++) begin
            st("to_busy", add, dv, C_BUSY);
            chk("to_busy t_busy", 32'(t_busy), 32'h1);
            chk("to_busy t_timeout", 32'(t_timeout), 32'h0);
        end
        st("to_done", add, dv, C_BUSY);
        chk("to_done t_busy", 32'(t_busy), 32'h0);
        chk("to_done t_timeout", 32'(t_timeout), 32'h1);
        chk("to_done t_exc", 32'(t_exc), 32'h1);
        chk("to_done t_result", t_result, 32'h0);
        chk("to_done t_pc_we", 32'(t_pc_we), 32'h1);
        st("to_after", add, add2, C_BUSY);
        chk("to_after t_timeout sticky", 32'(t_timeout), 32'h1);
        chk("to_after t_start_div", 32'(t_sd), 32'h0);

        do_reset();
        st("race_start", add, dv, C_MDD);
        for (int i = 1; i < 8; i++) st("race_busy", add, dv, C_BUSY);
        step("race_rdy", add, dv, 1'b0, 1'b1, 1'b0, 32'h0000_0055, 1'b1, C_BUSY);
        st("race_done", add, add2, C_NORM);
        chk("race t_result", t_result, 32'h0000_0055);
        chk("race t_exc", 32'(t_exc), 32'h0);
        chk("race t_timeout", 32'(t_timeout), 32'h0);
        chk("race md_result", md_result, 32'h0000_0055);

        st("rst_start", add, dv, C_MDD);
        st("rst_busy1", add, dv, C_BUSY);
        st("rst_busy2", add, dv, C_BUSY);
        step("rst_low1", add, dv, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, C_RST);
        chk("rst_low md_result", md_result, 32'h0);
        chk("rst_low md_busy", 32'(md_busy), 32'h0);
        chk("rst_low md_result_exc", 32'(md_result_exc), 32'h0);
        chk("rst_low t_result", t_result, 32'h0);
        chk("rst_low t_stall", 32'(t_stall), 32'h0);
        step("rst_low2", add, dv, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, C_RST);
        chk("rst_low2 md_timeout", 32'(md_timeout), 32'h0);
        st("rst_reissue", add, dv, C_MDD);
        st("rst_busy_again", add, dv, C_BUSY);
        chk("rst_busy_again md_busy", 32'(md_busy), 32'h1);
        step("rst_rdy", add, dv, 1'b0, 1'b1, 1'b0, 32'h0000_0077, 1'b1, C_BUSY);
        st("rst_done", add, dv, C_NORM);
        chk("rst_done md_result", md_result, 32'h0000_0077);

        do_reset();
        for (int i = 0; i < 20; i++) st("sat", add, dv, i == 0 ? C_MDD : C_BUSY);
        chk("sat t_stall", 32'(t_stall), 32'hF);
        chk("sat md_timeout", 32'(md_timeout), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
